io_out_serializer: RTL

- Parallel-to-serial stage directly upstream of the AP3 output IO register.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per CLK on SER_OUT, which feeds the IO register D input.
- Also produces a pad output-enable and a frame strobe.
- One holding buffer plus the shift register give gap-free back-to-back frames.

---
 rtl/io_out_serializer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/io_out_serializer.sv
// Parallel-to-serial stage feeding the output IO register: a holding buffer plus
// a shift register let back-to-back words leave on SER_OUT with no idle gap.
module io_out_serializer #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             SER_OUT,
    output logic             SER_OE,
    output logic             FRAME,
    output logic             BUSY
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // State encoding is {active, hold_valid}.
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PENDING      = 2'b01,
        SHIFT        = 2'b10,
        SHIFT_QUEUED = 2'b11
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             ser_out_reg, ser_out_next;
    logic             ser_oe_reg, ser_oe_next;
    logic             frame_reg, frame_next;

    logic             hold_valid, active, last_bit, accept, load;
    logic             first_bit, step_bit;
    logic [WIDTH-1:0] load_shift, step_shift;

    assign hold_valid = (state_reg == PENDING) || (state_reg == SHIFT_QUEUED);
    assign active     = (state_reg == SHIFT)   || (state_reg == SHIFT_QUEUED);
    assign last_bit   = (cnt_reg == LAST_CNT);
    assign accept     = DIN_VALID && !hold_valid;
    assign load       = hold_valid && (!active || last_bit);

    // shift_reg holds only the bits still to be sent, aligned so the next one
    // always sits at the same end.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign first_bit  = hold_reg[WIDTH-1];
            assign load_shift = {hold_reg[WIDTH-2:0], 1'b0};
            assign step_bit   = shift_reg[WIDTH-1];
            assign step_shift = {shift_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign first_bit  = hold_reg[0];
            assign load_shift = {1'b0, hold_reg[WIDTH-1:1]};
            assign step_bit   = shift_reg[0];
            assign step_shift = {1'b0, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        ser_out_next = ser_out_reg;
        ser_oe_next  = ser_oe_reg;
        frame_next   = 1'b0;

        if (accept) begin
            hold_next = DIN;
        end

        if (load) begin
            shift_next   = load_shift;
            cnt_next     = '0;
            ser_out_next = first_bit;
            ser_oe_next  = 1'b1;
            frame_next   = 1'b1;
        end else if (active && !last_bit) begin
            shift_next   = step_shift;
            cnt_next     = cnt_reg + CW'(1);
            ser_out_next = step_bit;
        end else if (active) begin
            ser_out_next = IDLE_LEVEL;
            ser_oe_next  = 1'b0;
        end

        case (state_reg)
            IDLE:         state_next = accept ? PENDING : IDLE;
            PENDING:      state_next = SHIFT;
            SHIFT: begin
                if (last_bit) state_next = accept ? PENDING : IDLE;
                else          state_next = accept ? SHIFT_QUEUED : SHIFT;
            end
            SHIFT_QUEUED: state_next = last_bit ? SHIFT : SHIFT_QUEUED;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            hold_reg    <= '0;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            ser_out_reg <= IDLE_LEVEL;
            ser_oe_reg  <= 1'b0;
            frame_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            ser_out_reg <= ser_out_next;
            ser_oe_reg  <= ser_oe_next;
            frame_reg   <= frame_next;
        end
    end

    assign DIN_READY = !hold_valid;
    assign BUSY      = (state_reg != IDLE);
    assign SER_OUT   = ser_out_reg;
    assign SER_OE    = ser_oe_reg;
    assign FRAME     = frame_reg;

endmodule
